// File: rtl/multi_alarm_editor_if.sv
// rtl/multi_alarm_editor_if.sv - button/time inputs and editor outputs of multi_alarm_editor
interface multi_alarm_editor_if #(
    parameter int NUM_ALARMS = 2
);
    localparam int T  = NUM_ALARMS + 1;
    localparam int FW = $clog2(2 * T);
    localparam int TW = $clog2(T);

    logic             btn_enter;
    logic             btn_left;
    logic             btn_right;
    logic             btn_up;
    logic             btn_down;
    logic [5*T-1:0]   cur_h_in;
    logic [6*T-1:0]   cur_m_in;
    logic             editing;
    logic [FW-1:0]    field_sel;
    logic [4:0]       edit_h;
    logic [5:0]       edit_m;
    logic             dirty;
    logic             commit_valid;
    logic [TW-1:0]    commit_target;
    logic [4:0]       commit_h;
    logic [5:0]       commit_m;
    logic [2*T-1:0]   led;

    modport master (
        output btn_enter, btn_left, btn_right, btn_up, btn_down, cur_h_in, cur_m_in,
        input  editing, field_sel, edit_h, edit_m, dirty,
               commit_valid, commit_target, commit_h, commit_m, led
    );

    modport slave (
        input  btn_enter, btn_left, btn_right, btn_up, btn_down, cur_h_in, cur_m_in,
        output editing, field_sel, edit_h, edit_m, dirty,
               commit_valid, commit_target, commit_h, commit_m, led
    );
endinterface

// File: rtl/multi_alarm_editor.sv
// rtl/multi_alarm_editor.sv - cursor editor over clock time and NUM_ALARMS alarms
module multi_alarm_editor #(
    parameter int NUM_ALARMS    = 2,
    parameter int HOURS_MAX     = 24,
    parameter bit CARRY_EN      = 1'b1,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100,
    parameter int TIMEOUT_CYC   = 10000
) (
    input logic                 clk,
    input logic                 reset,
    multi_alarm_editor_if.slave bus
);
    localparam int T    = NUM_ALARMS + 1;
    localparam int FW   = $clog2(2 * T);
    localparam int TW   = $clog2(T);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam int OW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FIELD_LAST = FW'(2 * T - 1);

    typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;
    state_t state, state_nx;

    logic [4:0]    btn, btn_q, btn_edge;
    logic [FW-1:0] field_sel, field_nx, field_new;
    logic [TW-1:0] tgt_new, commit_target, commit_target_nx;
    logic [4:0]    edit_h, edit_h_nx, orig_h, orig_h_nx, commit_h, commit_h_nx;
    logic [5:0]    edit_m, edit_m_nx, orig_m, orig_m_nx, commit_m, commit_m_nx;
    logic          dirty, dirty_nx, commit_valid, commit_valid_nx;
    logic          nav, do_step, rep_step;
    logic [RW-1:0] rcnt, rcnt_nx;
    logic          rphase, rphase_nx;
    logic [OW-1:0] idle_cnt, idle_nx;

    function automatic logic [4:0] hour_step(input logic [4:0] h, input logic up);
        if (up) return (h == 5'(HOURS_MAX - 1)) ? 5'd0 : h + 5'd1;
        return (h == 5'd0) ? 5'(HOURS_MAX - 1) : h - 5'd1;
    endfunction

    // bit order: enter, left, right, up, down
    assign btn       = {bus.btn_enter, bus.btn_left, bus.btn_right, bus.btn_up, bus.btn_down};
    assign btn_edge  = btn & ~btn_q;
    assign nav       = btn_edge[3] ^ btn_edge[2];
    assign field_new = btn_edge[2] ? ((field_sel == FIELD_LAST) ? '0 : field_sel + 1'b1)
                                   : ((field_sel == '0) ? FIELD_LAST : field_sel - 1'b1);
    assign tgt_new   = field_new[FW-1:1];

    always_comb begin
        state_nx         = state;
        field_nx         = field_sel;
        edit_h_nx        = edit_h;
        edit_m_nx        = edit_m;
        orig_h_nx        = orig_h;
        orig_m_nx        = orig_m;
        commit_valid_nx  = 1'b0;
        commit_target_nx = commit_target;
        commit_h_nx      = commit_h;
        commit_m_nx      = commit_m;
        rcnt_nx          = rcnt;
        rphase_nx        = rphase;
        idle_nx          = idle_cnt;
        do_step          = 1'b0;
        rep_step         = 1'b0;
        case (state)
            IDLE: begin
                if (btn_edge[4]) begin
                    state_nx  = EDIT;
                    edit_h_nx = bus.cur_h_in[4:0];
                    edit_m_nx = bus.cur_m_in[5:0];
                    orig_h_nx = bus.cur_h_in[4:0];
                    orig_m_nx = bus.cur_m_in[5:0];
                end
            end
            EDIT: begin
                if (btn_edge[4]) begin
                    state_nx         = COMMIT;
                    commit_valid_nx  = 1'b1;
                    commit_target_nx = field_sel[FW-1:1];
                    commit_h_nx      = edit_h;
                    commit_m_nx      = edit_m;
                end else if (nav) begin
                    field_nx = field_new;
                    if (tgt_new != field_sel[FW-1:1]) begin
                        if (dirty) begin
                            commit_valid_nx  = 1'b1;
                            commit_target_nx = field_sel[FW-1:1];
                            commit_h_nx      = edit_h;
                            commit_m_nx      = edit_m;
                        end
                        edit_h_nx = bus.cur_h_in[5*tgt_new +: 5];
                        edit_m_nx = bus.cur_m_in[6*tgt_new +: 6];
                        orig_h_nx = bus.cur_h_in[5*tgt_new +: 5];
                        orig_m_nx = bus.cur_m_in[6*tgt_new +: 6];
                    end
                end else if (btn[1] && btn[0]) begin
                    rcnt_nx   = '0;
                    rphase_nx = 1'b0;
                end else if (btn[1] || btn[0]) begin
                    // rcnt counts cycles since the last step; phase 0 waits the delay, phase 1 the period
                    if (btn_edge[1] || btn_edge[0]) begin
                        do_step   = 1'b1;
                        rcnt_nx   = RW'(1);
                        rphase_nx = 1'b0;
                    end else if (rcnt == (rphase ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY))) begin
                        do_step   = 1'b1;
                        rep_step  = 1'b1;
                        rcnt_nx   = RW'(1);
                        rphase_nx = 1'b1;
                    end else begin
                        rcnt_nx = rcnt + RW'(1);
                    end
                end else begin
                    rcnt_nx   = '0;
                    rphase_nx = 1'b0;
                end
                if (do_step) begin
                    if (!field_sel[0]) begin
                        edit_h_nx = hour_step(edit_h, btn[1]);
                    end else if (btn[1]) begin
                        edit_m_nx = (edit_m == 6'd59) ? 6'd0 : edit_m + 6'd1;
                        if (CARRY_EN && edit_m == 6'd59) edit_h_nx = hour_step(edit_h, 1'b1);
                    end else begin
                        edit_m_nx = (edit_m == 6'd0) ? 6'd59 : edit_m - 6'd1;
                        if (CARRY_EN && edit_m == 6'd0) edit_h_nx = hour_step(edit_h, 1'b0);
                    end
                end
                if ((|btn_edge) || rep_step) idle_nx = '0;
                else if (idle_cnt == OW'(TIMEOUT_CYC - 1)) state_nx = IDLE;
                else idle_nx = idle_cnt + OW'(1);
            end
            default: state_nx = IDLE;
        endcase
        if (state_nx != EDIT) begin
            rcnt_nx   = '0;
            rphase_nx = 1'b0;
            idle_nx   = '0;
        end
        if (state_nx == IDLE) field_nx = '0;
        dirty_nx = (state_nx != IDLE) && ((edit_h_nx != orig_h_nx) || (edit_m_nx != orig_m_nx));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            btn_q         <= '0;
            field_sel     <= '0;
            edit_h        <= '0;
            edit_m        <= '0;
            orig_h        <= '0;
            orig_m        <= '0;
            dirty         <= 1'b0;
            commit_valid  <= 1'b0;
            commit_target <= '0;
            commit_h      <= '0;
            commit_m      <= '0;
            rcnt          <= '0;
            rphase        <= 1'b0;
            idle_cnt      <= '0;
        end else begin
            state         <= state_nx;
            btn_q         <= btn;
            field_sel     <= field_nx;
            edit_h        <= edit_h_nx;
            edit_m        <= edit_m_nx;
            orig_h        <= orig_h_nx;
            orig_m        <= orig_m_nx;
            dirty         <= dirty_nx;
            commit_valid  <= commit_valid_nx;
            commit_target <= commit_target_nx;
            commit_h      <= commit_h_nx;
            commit_m      <= commit_m_nx;
            rcnt          <= rcnt_nx;
            rphase        <= rphase_nx;
            idle_cnt      <= idle_nx;
        end
    end

    assign bus.editing       = (state == EDIT);
    assign bus.field_sel     = field_sel;
    assign bus.edit_h        = edit_h;
    assign bus.edit_m        = edit_m;
    assign bus.dirty         = dirty;
    assign bus.commit_valid  = commit_valid;
    assign bus.commit_target = commit_target;
    assign bus.commit_h      = commit_h;
    assign bus.commit_m      = commit_m;
    assign bus.led           = (state == EDIT) ? ({{(2*T-1){1'b0}}, 1'b1} << field_sel) : '0;
endmodule

// File: tb/tb_multi_alarm_editor.sv
// tb/tb_multi_alarm_editor.sv - randomized scoreboard bench for multi_alarm_editor
module tb_multi_alarm_editor;
    localparam int NA = 2;
    localparam int T  = NA + 1;
    localparam int HM = 24;
    localparam int RD = 5;
    localparam int RP = 3;
    localparam int TO = 40;
    localparam logic [4:0] B_ENT = 5'b10000, B_L = 5'b01000, B_R = 5'b00100,
                           B_U = 5'b00010, B_D = 5'b00001;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [4:0]     btn = '0;
    logic [5*T-1:0] cur_h = '0;
    logic [6*T-1:0] cur_m = '0;
    int             n_chk = 0;
    int             n_fail = 0;

    always #5 clk = ~clk;

    multi_alarm_editor_if #(.NUM_ALARMS(NA)) bus_c ();
    multi_alarm_editor_if #(.NUM_ALARMS(NA)) bus_n ();

    assign {bus_c.btn_enter, bus_c.btn_left, bus_c.btn_right, bus_c.btn_up, bus_c.btn_down} = btn;
    assign {bus_n.btn_enter, bus_n.btn_left, bus_n.btn_right, bus_n.btn_up, bus_n.btn_down} = btn;
    assign bus_c.cur_h_in = cur_h;
    assign bus_c.cur_m_in = cur_m;
    assign bus_n.cur_h_in = cur_h;
    assign bus_n.cur_m_in = cur_m;

    multi_alarm_editor #(.NUM_ALARMS(NA), .HOURS_MAX(HM), .CARRY_EN(1'b1), .REPEAT_DELAY(RD),
                         .REPEAT_PERIOD(RP), .TIMEOUT_CYC(TO))
        dut_c (.clk(clk), .reset(reset), .bus(bus_c.slave));
    multi_alarm_editor #(.NUM_ALARMS(NA), .HOURS_MAX(HM), .CARRY_EN(1'b0), .REPEAT_DELAY(RD),
                         .REPEAT_PERIOD(RP), .TIMEOUT_CYC(TO))
        dut_n (.clk(clk), .reset(reset), .bus(bus_n.slave));

    // Reference model: st 0=idle 1=edit 2=commit; age = cycles an up/down has been held (-1 = none)
    typedef struct { int st, fld, h, m, oh, om, age, idle, ct, ch, cm; } mstate_t;
    mstate_t    ms [2];
    int         q0[$];
    int         q1[$];
    logic [4:0] m_prev;

    function automatic bit m_dirty(int k);
        return ms[k].st != 0 && (ms[k].h != ms[k].oh || ms[k].m != ms[k].om);
    endfunction

    function automatic void m_load(int k, int t);
        ms[k].h  = int'(cur_h[5*t +: 5]);
        ms[k].m  = int'(cur_m[6*t +: 6]);
        ms[k].oh = ms[k].h;
        ms[k].om = ms[k].m;
    endfunction

    function automatic void m_commit(int k);
        ms[k].ct = ms[k].fld / 2;
        ms[k].ch = ms[k].h;
        ms[k].cm = ms[k].m;
        if (k == 0) q0.push_back(ms[k].ct * 10000 + ms[k].h * 100 + ms[k].m);
        else        q1.push_back(ms[k].ct * 10000 + ms[k].h * 100 + ms[k].m);
    endfunction

    function automatic void m_apply(int k, bit up);
        int tot;
        if (ms[k].fld % 2 == 0) begin
            ms[k].h = (ms[k].h + (up ? 1 : HM - 1)) % HM;
        end else if (k == 0) begin
            tot = (ms[k].h * 60 + ms[k].m + (up ? 1 : HM * 60 - 1)) % (HM * 60);
            ms[k].h = tot / 60;
            ms[k].m = tot % 60;
        end else begin
            ms[k].m = (ms[k].m + (up ? 1 : 59)) % 60;
        end
    endfunction

    function automatic void m_step(int k, logic [4:0] now);
        logic [4:0] e;
        int nf;
        bit rep;
        e   = now & ~m_prev;
        rep = 1'b0;
        if (ms[k].st == 0) begin
            ms[k].age = -1;
            if (e[4]) begin ms[k].st = 1; ms[k].fld = 0; ms[k].idle = 0; m_load(k, 0); end
        end else if (ms[k].st == 2) begin
            ms[k].st  = 0;
            ms[k].age = -1;
        end else begin
            if (e[4]) begin
                m_commit(k);
                ms[k].st = 2;
            end else if (e[3] != e[2]) begin
                nf = e[2] ? (ms[k].fld + 1) % (2 * T) : (ms[k].fld + 2 * T - 1) % (2 * T);
                if (nf / 2 != ms[k].fld / 2) begin
                    if (m_dirty(k)) m_commit(k);
                    m_load(k, nf / 2);
                end
                ms[k].fld = nf;
            end else if (now[1] && now[0]) begin
                ms[k].age = -1;
            end else if (now[1] || now[0]) begin
                if (e[1] || e[0]) begin
                    ms[k].age = 0;
                    m_apply(k, now[1]);
                end else begin
                    ms[k].age++;
                    if (ms[k].age >= RD && (ms[k].age - RD) % RP == 0) begin
                        rep = 1'b1;
                        m_apply(k, now[1]);
                    end
                end
            end else begin
                ms[k].age = -1;
            end
            if (ms[k].st == 1) begin
                if (e != 0 || rep) ms[k].idle = 0;
                else begin
                    ms[k].idle++;
                    if (ms[k].idle == TO) ms[k].st = 0;
                end
            end
        end
        if (ms[k].st == 0) ms[k].fld = 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                ms[k] = '{default: 0};
                ms[k].age = -1;
            end
            q0.delete();
            q1.delete();
            m_prev = '0;
        end else begin
            for (int k = 0; k < 2; k++) m_step(k, btn);
            m_prev = btn;
        end
    end

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_inst(int k, string tag, logic ed, logic [2:0] fs, logic [4:0] eh,
                              logic [5:0] em, logic dt, logic cv, logic [1:0] ct,
                              logic [4:0] ch, logic [5:0] cm, logic [5:0] led);
        int v;
        v = -1;
        chk({tag, ".editing"}, int'(ed), int'(ms[k].st == 1));
        chk({tag, ".field_sel"}, int'(fs), ms[k].fld);
        chk({tag, ".edit_h"}, int'(eh), ms[k].h);
        chk({tag, ".edit_m"}, int'(em), ms[k].m);
        chk({tag, ".dirty"}, int'(dt), int'(m_dirty(k)));
        chk({tag, ".led"}, int'(led), (ms[k].st == 1) ? (1 << ms[k].fld) : 0);
        if (k == 0 && q0.size() > 0) v = q0.pop_front();
        if (k == 1 && q1.size() > 0) v = q1.pop_front();
        if (cv || v >= 0)
            chk({tag, ".commit"}, cv ? int'(ct) * 10000 + int'(ch) * 100 + int'(cm) : -2, v);
        chk({tag, ".commit_hold"}, int'(ct) * 10000 + int'(ch) * 100 + int'(cm),
            ms[k].ct * 10000 + ms[k].ch * 100 + ms[k].cm);
    endtask

    always @(negedge clk) begin
        check_inst(0, "carry", bus_c.editing, bus_c.field_sel, bus_c.edit_h, bus_c.edit_m,
                   bus_c.dirty, bus_c.commit_valid, bus_c.commit_target, bus_c.commit_h,
                   bus_c.commit_m, bus_c.led);
        check_inst(1, "nocarry", bus_n.editing, bus_n.field_sel, bus_n.edit_h, bus_n.edit_m,
                   bus_n.dirty, bus_n.commit_valid, bus_n.commit_target, bus_n.commit_h,
                   bus_n.commit_m, bus_n.led);
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(logic [4:0] b, int hold, int gap);
        btn = b;
        tick(hold);
        btn = '0;
        tick(gap);
    endtask

    task automatic set_cur(int t, int h, int m);
        cur_h[5*t +: 5] = 5'(h);
        cur_m[6*t +: 6] = 6'(m);
    endtask

    task automatic rand_cur();
        for (int t = 0; t < T; t++) set_cur(t, $urandom_range(0, HM - 1), $urandom_range(0, 59));
    endtask

    initial begin
        int r;
        #1 reset = 1'b1;
        set_cur(0, 10, 15);
        set_cur(1, 7, 30);
        set_cur(2, 22, 45);
        tick(3);
        reset = 1'b0;
        tick(2);
        // enter loads 10:15, unmodified commit
        press(B_ENT, 1, 2);
        press(B_ENT, 1, 3);
        // 10:59 + 1 minute
        set_cur(0, 10, 59);
        press(B_ENT, 1, 1); press(B_R, 1, 1); press(B_U, 1, 1); press(B_ENT, 1, 3);
        // hour wrap 23 -> 0
        set_cur(0, 23, 0);
        press(B_ENT, 1, 1); press(B_U, 1, 1); press(B_ENT, 1, 3);
        // minute borrow from 00:00
        set_cur(0, 0, 0);
        press(B_ENT, 1, 1); press(B_R, 1, 1); press(B_D, 1, 1); press(B_ENT, 1, 3);
        // auto-repeat, then up+down together
        press(B_ENT, 1, 1); press(B_R, 1, 1);
        press(B_U, RD + 3 * RP, 1);
        press(B_U | B_D, 20, 1);
        press(B_ENT, 1, 3);
        // nav-commit across targets and left wrap
        rand_cur();
        press(B_ENT, 1, 1); press(B_U, 1, 1); press(B_R, 1, 1); press(B_R, 1, 1);
        press(B_L, 1, 1); press(B_L, 1, 1); press(B_L, 1, 1); press(B_ENT, 1, 3);
        // timeout discards a dirty edit
        press(B_ENT, 1, 1); press(B_U, 1, 1); tick(TO + 5);
        // reset mid-edit
        press(B_ENT, 1, 1); press(B_U, 1, 2);
        reset = 1'b1; tick(2); reset = 1'b0; tick(2);
        for (int i = 0; i < 400; i++) begin
            if (i % 20 == 0) rand_cur();
            r = $urandom_range(0, 99);
            if (r < 4) tick(TO + 2);
            else if (r < 14) press(B_ENT, $urandom_range(1, 3), $urandom_range(0, 3));
            else if (r < 32) press(B_L, $urandom_range(1, 4), $urandom_range(0, 3));
            else if (r < 50) press(B_R, $urandom_range(1, 4), $urandom_range(0, 3));
            else if (r < 72) press(B_U, $urandom_range(1, 14), $urandom_range(0, 3));
            else if (r < 94) press(B_D, $urandom_range(1, 14), $urandom_range(0, 3));
            else press(5'(1 << $urandom_range(0, 4)) | 5'(1 << $urandom_range(0, 4)),
                       $urandom_range(1, 6), $urandom_range(0, 3));
        end
        tick(10);
        chk("pending_commits", q0.size() + q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
